// File: rtl/rice_core_trap_ctrl.sv
// Machine-mode trap controller: trap CSRs, privilege tracking, irq sync/priority, vectored mtvec.
// Latency: trap/mret redirect and CSR responses are registered, one cycle after the request.
// Backpressure: CSR requests are held off while an event is taken or a flush is in progress; the requester retries.
module rice_core_trap_ctrl #(
  parameter int unsigned     XLEN        = 32,
  parameter int unsigned     EXCEPTIONS  = 16,
  parameter bit              VECTORED    = 1'b1,
  parameter int unsigned     SYNC_STAGES = 2,
  parameter logic [XLEN-1:0] MTVEC_RESET = '0
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic [XLEN-1:0]       i_pc,
  input  logic                  i_inst_valid,
  input  logic [EXCEPTIONS-1:0] i_exception,
  input  logic [XLEN-1:0]       i_tval,
  input  logic                  i_mret,
  input  logic                  i_irq_ext,
  input  logic                  i_irq_timer,
  input  logic                  i_irq_soft,
  output logic [1:0]            o_privilege_level,
  output logic                  o_flush,
  output logic [XLEN-1:0]       o_flush_pc,
  input  logic                  i_csr_valid,
  input  logic [11:0]           i_csr_address,
  input  logic                  i_csr_write,
  input  logic [XLEN-1:0]       i_csr_wdata,
  input  logic [XLEN-1:0]       i_csr_wmask,
  output logic                  o_csr_ack,
  output logic [XLEN-1:0]       o_csr_rdata,
  output logic                  o_csr_error
);

  localparam logic [1:0] PRIV_M = 2'b11;
  localparam logic [1:0] PRIV_U = 2'b00;

  typedef enum logic {ST_RUN, ST_FLUSH} state_t;

  state_t          state_q;
  logic [1:0]      priv_q;
  logic            mstatus_mie_q;
  logic            mstatus_mpie_q;
  logic [1:0]      mstatus_mpp_q;
  logic [2:0]      mie_q;            // {MEIE, MTIE, MSIE}
  logic [XLEN-1:0] mtvec_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [XLEN-1:0] mscratch_q;
  logic [2:0]      irq_sync [SYNC_STAGES];  // each stage {ext, timer, soft}

  logic [2:0]      mip;
  logic [2:0]      pend;
  logic            exc_vld;
  logic [XLEN-1:0] exc_code;
  logic [XLEN-1:0] int_code;
  logic            run;
  logic            take_exc;
  logic            take_mret;
  logic            take_int;
  logic            take_event;
  logic            csr_acc;
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] flush_target;
  logic [XLEN-1:0] csr_rd;
  logic            csr_hit;
  logic [XLEN-1:0] csr_wr_val;

  assign o_privilege_level = priv_q;
  assign mip  = irq_sync[SYNC_STAGES-1];
  assign pend = mip & mie_q;

  // Interrupt lines cross into this clock domain through a plain flop chain
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) irq_sync[i] <= 3'b000;
    end else begin
      irq_sync[0] <= {i_irq_ext, i_irq_timer, i_irq_soft};
      for (int i = 1; i < SYNC_STAGES; i++) irq_sync[i] <= irq_sync[i-1];
    end
  end

  // Lowest set exception bit wins; scan from the top so the last hit is the lowest
  always_comb begin
    exc_code = '0;
    for (int i = EXCEPTIONS - 1; i >= 0; i--) begin
      if (i_exception[i]) exc_code = XLEN'(i);
    end
  end

  assign exc_vld = |i_exception;

  // Interrupt priority MEI > MSI > MTI
  always_comb begin
    int_code = XLEN'(7);
    if (pend[2])      int_code = XLEN'(11);
    else if (pend[0]) int_code = XLEN'(3);
  end

  // Event arbitration: exception over mret over interrupt, only while running
  always_comb begin
    run        = i_enable && (state_q == ST_RUN);
    take_exc   = run && exc_vld;
    take_mret  = run && !exc_vld && i_mret;
    take_int   = run && !exc_vld && !i_mret && i_inst_valid && (|pend) &&
                 ((priv_q == PRIV_U) || mstatus_mie_q);
    take_event = take_exc || take_mret || take_int;
    csr_acc    = run && i_csr_valid && !take_event;
  end

  // Redirect target: mepc for mret, mtvec base, plus a code offset for vectored interrupts
  always_comb begin
    mtvec_base   = {mtvec_q[XLEN-1:2], 2'b00};
    flush_target = mtvec_base;
    if (take_mret)                              flush_target = mepc_q;
    else if (take_int && mtvec_q[1:0] == 2'b01) flush_target = mtvec_base + (int_code << 2);
  end

  // CSR read mux; the merged write value is built from the current contents
  always_comb begin
    csr_rd  = '0;
    csr_hit = 1'b1;
    case (i_csr_address)
      12'h300: begin
        csr_rd[3]     = mstatus_mie_q;
        csr_rd[7]     = mstatus_mpie_q;
        csr_rd[12:11] = mstatus_mpp_q;
      end
      12'h304: begin
        csr_rd[3]  = mie_q[0];
        csr_rd[7]  = mie_q[1];
        csr_rd[11] = mie_q[2];
      end
      12'h305: csr_rd = mtvec_q;
      12'h340: csr_rd = mscratch_q;
      12'h341: csr_rd = mepc_q;
      12'h342: csr_rd = mcause_q;
      12'h343: csr_rd = mtval_q;
      12'h344: begin
        csr_rd[3]  = mip[0];
        csr_rd[7]  = mip[1];
        csr_rd[11] = mip[2];
      end
      default: csr_hit = 1'b0;
    endcase
    csr_wr_val = (csr_rd & ~i_csr_wmask) | (i_csr_wdata & i_csr_wmask);
  end

  // RUN/FLUSH state machine owning CSR state, privilege and all registered outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q        <= ST_RUN;
      priv_q         <= PRIV_M;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mstatus_mpp_q  <= PRIV_M;
      mie_q          <= 3'b000;
      mtvec_q        <= MTVEC_RESET;
      mepc_q         <= '0;
      mcause_q       <= '0;
      mtval_q        <= '0;
      mscratch_q     <= '0;
      o_flush        <= 1'b0;
      o_flush_pc     <= '0;
      o_csr_ack      <= 1'b0;
      o_csr_rdata    <= '0;
      o_csr_error    <= 1'b0;
    end else begin
      o_flush     <= 1'b0;
      o_csr_ack   <= 1'b0;
      o_csr_error <= 1'b0;
      if (!i_enable) begin
        priv_q  <= PRIV_M;
        state_q <= ST_RUN;
      end else begin
        case (state_q)
          ST_RUN: begin
            if (take_event) begin
              state_q    <= ST_FLUSH;
              o_flush    <= 1'b1;
              o_flush_pc <= flush_target;
              if (take_mret) begin
                priv_q         <= mstatus_mpp_q;
                mstatus_mie_q  <= mstatus_mpie_q;
                mstatus_mpie_q <= 1'b1;
                mstatus_mpp_q  <= PRIV_U;
              end else begin
                mepc_q         <= {i_pc[XLEN-1:2], 2'b00};
                mcause_q       <= take_int ? {1'b1, int_code[XLEN-2:0]} : exc_code;
                mtval_q        <= take_int ? '0 : i_tval;
                mstatus_mpie_q <= mstatus_mie_q;
                mstatus_mie_q  <= 1'b0;
                mstatus_mpp_q  <= priv_q;
                priv_q         <= PRIV_M;
              end
            end else if (csr_acc) begin
              o_csr_ack   <= 1'b1;
              o_csr_error <= !csr_hit;
              o_csr_rdata <= csr_rd;
              if (i_csr_write) begin
                case (i_csr_address)
                  12'h300: begin
                    mstatus_mie_q  <= csr_wr_val[3];
                    mstatus_mpie_q <= csr_wr_val[7];
                    mstatus_mpp_q  <= (csr_wr_val[12:11] == PRIV_U) ? PRIV_U : PRIV_M;
                  end
                  12'h304: mie_q <= {csr_wr_val[11], csr_wr_val[7], csr_wr_val[3]};
                  12'h305: mtvec_q <= {csr_wr_val[XLEN-1:2],
                                       (VECTORED && csr_wr_val[1:0] == 2'b01) ? 2'b01 : 2'b00};
                  12'h340: mscratch_q <= csr_wr_val;
                  12'h341: mepc_q     <= {csr_wr_val[XLEN-1:2], 2'b00};
                  12'h342: mcause_q   <= csr_wr_val;
                  12'h343: mtval_q    <= csr_wr_val;
                  default: ;
                endcase
              end
            end
          end
          default: state_q <= ST_RUN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rice_core_trap_ctrl.sv
// Directed bench for rice_core_trap_ctrl: CSR vector table plus trap/mret/irq sequences.
// Latency: checks registered responses one cycle after each request.
// Backpressure: CSR requests are held until ack, bounded by a cycle budget.
module tb_rice_core_trap_ctrl;

  localparam logic [31:0] MTVEC_RST = 32'h0000_0080;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b1;
  logic [31:0] i_pc = '0;
  logic        i_inst_valid = 1'b0;
  logic [15:0] i_exception = '0;
  logic [31:0] i_tval = '0;
  logic        i_mret = 1'b0;
  logic        i_irq_ext = 1'b0;
  logic        i_irq_timer = 1'b0;
  logic        i_irq_soft = 1'b0;
  logic [1:0]  o_privilege_level;
  logic        o_flush;
  logic [31:0] o_flush_pc;
  logic        i_csr_valid = 1'b0;
  logic [11:0] i_csr_address = '0;
  logic        i_csr_write = 1'b0;
  logic [31:0] i_csr_wdata = '0;
  logic [31:0] i_csr_wmask = '0;
  logic        o_csr_ack;
  logic [31:0] o_csr_rdata;
  logic        o_csr_error;

  int tests = 0;
  int fails = 0;

  rice_core_trap_ctrl #(
    .XLEN(32), .EXCEPTIONS(16), .VECTORED(1'b1), .SYNC_STAGES(2), .MTVEC_RESET(MTVEC_RST)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_pc(i_pc),
    .i_inst_valid(i_inst_valid), .i_exception(i_exception), .i_tval(i_tval),
    .i_mret(i_mret), .i_irq_ext(i_irq_ext), .i_irq_timer(i_irq_timer),
    .i_irq_soft(i_irq_soft), .o_privilege_level(o_privilege_level),
    .o_flush(o_flush), .o_flush_pc(o_flush_pc), .i_csr_valid(i_csr_valid),
    .i_csr_address(i_csr_address), .i_csr_write(i_csr_write),
    .i_csr_wdata(i_csr_wdata), .i_csr_wmask(i_csr_wmask), .o_csr_ack(o_csr_ack),
    .o_csr_rdata(o_csr_rdata), .o_csr_error(o_csr_error)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] wmask;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one CSR access and hold it until ack or the budget runs out
  task automatic csr(input logic wr, input logic [11:0] a, input logic [31:0] d,
                     input logic [31:0] m, output logic [31:0] rd, output logic er);
    int n;
    @(negedge i_clk);
    i_csr_valid = 1'b1; i_csr_write = wr; i_csr_address = a;
    i_csr_wdata = d; i_csr_wmask = m;
    n = 0;
    do begin
      @(posedge i_clk); #1; n++;
    end while (!o_csr_ack && n < 10);
    chk("csr_ack", {31'd0, o_csr_ack}, 32'd1);
    rd = o_csr_rdata;
    er = o_csr_error;
    @(negedge i_clk);
    i_csr_valid = 1'b0; i_csr_write = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d, input logic [31:0] m);
    logic [31:0] rd; logic er;
    csr(1'b1, a, d, m, rd, er);
  endtask

  task automatic csr_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic er;
    csr(1'b0, a, 32'd0, 32'd0, rd, er);
    chk(name, rd, exp);
  endtask

  // Wait a bounded number of cycles for a redirect pulse
  task automatic wait_flush(input string name);
    int n;
    n = 0;
    do begin
      @(posedge i_clk); #1; n++;
    end while (!o_flush && n < 20);
    chk(name, {31'd0, o_flush}, 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    //          wr    addr     wdata         wmask         exp_rd        err
    tbl[0]  = '{1'b0, 12'h300, 32'h0,        32'h0,        32'h0000_1800, 1'b0};
    tbl[1]  = '{1'b0, 12'h305, 32'h0,        32'h0,        MTVEC_RST,     1'b0};
    tbl[2]  = '{1'b0, 12'h7C0, 32'h0,        32'h0,        32'h0,         1'b1};
    tbl[3]  = '{1'b1, 12'h300, 32'h0000_0800, 32'h0000_1800, 32'h0000_1800, 1'b0};
    tbl[4]  = '{1'b0, 12'h300, 32'h0,        32'h0,        32'h0000_1800, 1'b0};
    tbl[5]  = '{1'b1, 12'h340, 32'hCAFE_BABE, 32'hFFFF_0000, 32'h0,         1'b0};
    tbl[6]  = '{1'b0, 12'h340, 32'h0,        32'h0,        32'hCAFE_0000, 1'b0};
    tbl[7]  = '{1'b1, 12'h305, 32'h0000_0103, 32'hFFFF_FFFF, MTVEC_RST,     1'b0};
    tbl[8]  = '{1'b0, 12'h305, 32'h0,        32'h0,        32'h0000_0100, 1'b0};
    tbl[9]  = '{1'b1, 12'h344, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[10] = '{1'b0, 12'h344, 32'h0,        32'h0,        32'h0,         1'b0};
    tbl[11] = '{1'b1, 12'h341, 32'h0000_0047, 32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[12] = '{1'b0, 12'h341, 32'h0,        32'h0,        32'h0000_0044, 1'b0};
    tbl[13] = '{1'b1, 12'h7C0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         1'b1};

    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    @(posedge i_clk); #1;
    chk("rst_priv", {30'd0, o_privilege_level}, 32'd3);
    chk("rst_flush", {31'd0, o_flush}, 32'd0);
    chk("rst_flush_pc", o_flush_pc, 32'd0);
    chk("rst_ack", {31'd0, o_csr_ack}, 32'd0);
    chk("rst_rdata", o_csr_rdata, 32'd0);
    chk("rst_err", {31'd0, o_csr_error}, 32'd0);

    for (int i = 0; i < 14; i++) begin
      csr(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wmask, rd, er);
      chk($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, er}, {31'd0, tbl[i].exp_err});
    end

    // Exception: lowest bit wins, non-vectored base target
    csr_wr(12'h305, 32'h0000_0100, 32'hFFFF_FFFF);
    csr_wr(12'h300, 32'h0000_0008, 32'h0000_0008);
    @(negedge i_clk);
    i_exception = 16'h0024; i_pc = 32'h40; i_tval = 32'hDEAD;
    @(posedge i_clk); #1;
    chk("exc_flush", {31'd0, o_flush}, 32'd1);
    chk("exc_flush_pc", o_flush_pc, 32'h100);
    @(negedge i_clk);
    i_exception = '0;
    @(posedge i_clk); #1;
    chk("exc_flush_one_cycle", {31'd0, o_flush}, 32'd0);
    csr_chk("exc_mcause", 12'h342, 32'd2);
    csr_chk("exc_mepc", 12'h341, 32'h40);
    csr_chk("exc_mtval", 12'h343, 32'hDEAD);
    csr_chk("exc_mstatus", 12'h300, 32'h0000_1880);

    // Vectored external interrupt, gated by instruction boundary
    csr_wr(12'h305, 32'h0000_0101, 32'hFFFF_FFFF);
    csr_wr(12'h300, 32'h0000_0008, 32'h0000_0008);
    csr_wr(12'h304, 32'h0000_0800, 32'hFFFF_FFFF);
    @(negedge i_clk);
    i_irq_ext = 1'b1; i_pc = 32'h80;
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("irq_needs_inst_valid", {31'd0, o_flush}, 32'd0);
    end
    csr_chk("irq_mip", 12'h344, 32'h0000_0800);
    @(negedge i_clk);
    i_inst_valid = 1'b1;
    @(posedge i_clk); #1;
    chk("mei_flush", {31'd0, o_flush}, 32'd1);
    chk("mei_flush_pc", o_flush_pc, 32'h12C);
    @(negedge i_clk);
    i_inst_valid = 1'b0; i_irq_ext = 1'b0;
    csr_chk("mei_mcause", 12'h342, 32'h8000_000B);
    csr_chk("mei_mtval", 12'h343, 32'h0);
    csr_chk("mei_mstatus", 12'h300, 32'h0000_1880);

    // mret into U-mode, then timer interrupt with MIE clear
    csr_wr(12'h300, 32'h0, 32'h0000_1800);
    csr_wr(12'h341, 32'h0000_0200, 32'hFFFF_FFFF);
    @(negedge i_clk);
    i_mret = 1'b1;
    @(posedge i_clk); #1;
    chk("mret_flush", {31'd0, o_flush}, 32'd1);
    chk("mret_flush_pc", o_flush_pc, 32'h200);
    chk("mret_priv_u", {30'd0, o_privilege_level}, 32'd0);
    @(negedge i_clk);
    i_mret = 1'b0;
    csr_chk("mret_mstatus", 12'h300, 32'h0000_0088);
    csr_wr(12'h300, 32'h0, 32'h0000_0008);
    csr_wr(12'h304, 32'h0000_0080, 32'hFFFF_FFFF);
    @(negedge i_clk);
    i_irq_timer = 1'b1; i_inst_valid = 1'b1; i_pc = 32'h300;
    wait_flush("mti_flush");
    chk("mti_flush_pc", o_flush_pc, 32'h11C);
    chk("mti_priv", {30'd0, o_privilege_level}, 32'd3);
    @(negedge i_clk);
    i_irq_timer = 1'b0; i_inst_valid = 1'b0;
    csr_chk("mti_mstatus", 12'h300, 32'h0);
    csr_chk("mti_mcause", 12'h342, 32'h8000_0007);
    csr_wr(12'h304, 32'h0, 32'hFFFF_FFFF);

    // Exception beats a coincident mret
    @(negedge i_clk);
    i_mret = 1'b1; i_exception = 16'h0008; i_pc = 32'h60; i_tval = 32'h11;
    @(posedge i_clk); #1;
    chk("exc_mret_flush_pc", o_flush_pc, 32'h100);
    chk("exc_mret_priv", {30'd0, o_privilege_level}, 32'd3);
    @(negedge i_clk);
    i_mret = 1'b0; i_exception = '0;
    csr_chk("exc_mret_mcause", 12'h342, 32'd3);
    csr_chk("exc_mret_mepc", 12'h341, 32'h60);

    // CSR write coincident with an exception is held off, then applied
    @(negedge i_clk);
    i_csr_valid = 1'b1; i_csr_write = 1'b1; i_csr_address = 12'h340;
    i_csr_wdata = 32'h1234; i_csr_wmask = 32'hFFFF_FFFF; i_exception = 16'h0001;
    @(posedge i_clk); #1;
    chk("coll_no_ack", {31'd0, o_csr_ack}, 32'd0);
    chk("coll_flush", {31'd0, o_flush}, 32'd1);
    @(negedge i_clk);
    i_exception = '0;
    @(posedge i_clk); #1;
    chk("coll_no_ack_in_flush", {31'd0, o_csr_ack}, 32'd0);
    @(posedge i_clk); #1;
    chk("coll_retry_ack", {31'd0, o_csr_ack}, 32'd1);
    chk("coll_retry_old", o_csr_rdata, 32'hCAFE_0000);
    @(negedge i_clk);
    i_csr_valid = 1'b0; i_csr_write = 1'b0;
    csr_chk("coll_applied", 12'h340, 32'h1234);

    // Disable forces M and stalls CSR acks, contents retained
    csr_wr(12'h300, 32'h0, 32'h0000_1800);
    @(negedge i_clk);
    i_mret = 1'b1;
    @(posedge i_clk); #1;
    chk("pre_dis_priv_u", {30'd0, o_privilege_level}, 32'd0);
    @(negedge i_clk);
    i_mret = 1'b0; i_enable = 1'b0;
    i_csr_valid = 1'b1; i_csr_write = 1'b0; i_csr_address = 12'h340;
    repeat (3) begin
      @(posedge i_clk); #1;
      chk("dis_no_ack", {31'd0, o_csr_ack}, 32'd0);
    end
    chk("dis_priv_m", {30'd0, o_privilege_level}, 32'd3);
    @(negedge i_clk);
    i_csr_valid = 1'b0; i_enable = 1'b1;
    csr_chk("dis_kept", 12'h340, 32'h1234);

    // Reset during a pending request: no ack, contents back to reset
    @(negedge i_clk);
    i_csr_valid = 1'b1; i_csr_address = 12'h340; i_rst = 1'b1;
    @(posedge i_clk); #1;
    chk("rst_mid_no_ack", {31'd0, o_csr_ack}, 32'd0);
    @(negedge i_clk);
    i_csr_valid = 1'b0; i_rst = 1'b0;
    csr_chk("rst_mid_mscratch", 12'h340, 32'h0);
    csr_chk("rst_mid_mtvec", 12'h305, MTVEC_RST);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rice_core_trap_ctrl.md
# rice_core_trap_ctrl

Machine-mode trap controller for the rice core, parametrised successor of the core environment block. It owns the trap CSRs (mstatus, mie, mip, mtvec, mepc, mcause, mtval, mscratch), tracks privilege level, synchronises and prioritises machine interrupts, and supports vectored mtvec mode. It sits beside the pipeline. It issues a registered flush/redirect on every trap or mret, and serves CSR accesses through a registered request/acknowledge port.

## Interface
- XLEN, 32, data/PC width (32 or 64)
- EXCEPTIONS, 16, width of exception request vector; bit index = exception code
- VECTORED, 1, 1 allows mtvec.MODE=1; 0 ties MODE to 0
- SYNC_STAGES, 2, irq synchroniser depth (>=1)
- MTVEC_RESET, 0, reset value of mtvec (XLEN bits)

Ports:
- i_clk  in  1  clock, single clock domain
- i_rst  in  1  reset, asynchronous, active-high
- i_enable  in  1  core enable; low = hold privilege M, take no events
- i_pc  in  XLEN  PC of instruction at commit
- i_inst_valid  in  1  instruction boundary; interrupts taken only here
- i_exception  in  EXCEPTIONS  exception requests for i_pc
- i_tval  in  XLEN  trap value for exception
- i_mret  in  1  mret committing
- i_irq_ext / i_irq_timer / i_irq_soft  in  1 each  async level interrupts
- o_privilege_level  out  2  2'b11 M, 2'b00 U
- o_flush  out  1  one-cycle redirect pulse
- o_flush_pc  out  XLEN  redirect target, valid with o_flush
- i_csr_valid  in  1  CSR request
- i_csr_address  in  12  CSR address
- i_csr_write  in  1  1 write, 0 read
- i_csr_wdata / i_csr_wmask  in  XLEN  write data / bit enables
- o_csr_ack  out  1  response pulse
- o_csr_rdata  out  XLEN  read data (old value on write)
- o_csr_error  out  1  unimplemented address

## Operation
- CSR fields: mstatus MIE[3], MPIE[7], MPP[12:11]; mie MSIE[3], MTIE[7], MEIE[11]; mip MSIP/MTIP/MEIP same bits, read-only, from synchronised irqs; mtvec BASE[XLEN-1:2], MODE[1:0]; mepc bits[1:0] read 0; mcause interrupt bit XLEN-1, code below; mtval, mscratch full width.
- Address map: 0x300 mstatus, 0x304 mie, 0x305 mtvec, 0x340 mscratch, 0x341 mepc, 0x342 mcause, 0x343 mtval, 0x344 mip. Anything else: error=1, rdata=0, no write.
- WARL: MPP write of 01/10 stores 11; MODE write other than 0 or (1 with VECTORED) stores 0; writes to mip ignored, no error.
- Event priority per cycle: exception (any i_exception bit) > mret > interrupt. Exception code = lowest set bit index.
- Interrupt pending = mip & mie, globally enabled when privilege U or mstatus.MIE=1, taken only with i_inst_valid. Priority MEI(11) > MSI(3) > MTI(7).
- Trap: mepc<=i_pc; mcause<={intr, code}; mtval<=i_tval for exception, 0 for interrupt; MPIE<=MIE; MIE<=0; MPP<=privilege; privilege<=M.
- Target: BASE<<2; if MODE=1 and interrupt, BASE<<2 + 4*code.
- mret: privilege<=MPP; MIE<=MPIE; MPIE<=1; MPP<=2'b00 (U). Target mepc.
- FSM RUN/FLUSH: event in RUN -> FLUSH, o_flush=1 for that cycle; FLUSH -> RUN unconditionally. Events and CSR requests ignored while in FLUSH.
- CSR request accepted in RUN when no event that cycle; write applies (old & ~mask | wdata & mask).
- i_enable low: privilege<=M, FSM<=RUN, no events, CSR requests not acked; CSR contents kept.

## Timing
- Reset: privilege 11, MIE/MPIE 0, MPP 11, mie 0, mtvec MTVEC_RESET, others 0; o_flush 0, o_flush_pc 0, o_csr_ack 0, o_csr_rdata 0, o_csr_error 0; FSM RUN; synchronisers 0.
- Event in cycle N: CSR/privilege updated at edge N+1; o_flush/o_flush_pc registered, high in cycle N+1 only.
- CSR: request accepted in cycle N -> ack/rdata/error in cycle N+1; write visible to reads in N+1. Requester holds valid until ack.
- Request coincident with event: not accepted, retried.
- irq edge -> mip set after SYNC_STAGES cycles; takeable the following cycle.
- Reset mid-FLUSH or mid-request: immediate return to reset values; no ack or flush emitted.

## Test plan
- Reset, read 0x300 -> ack next cycle, rdata 0x1800; read 0x305 -> MTVEC_RESET.
- mtvec=0x100, i_exception bits 2 and 5 with i_pc=0x40, i_tval=0xDEAD -> o_flush next cycle, pc 0x100, mcause 2, mepc 0x40, mtval 0xDEAD, MIE 0.
- mtvec=0x101, MIE=1, MEIE=1, i_irq_ext raised -> after 2 sync cycles, at i_inst_valid flush to 0x12C, mcause 0x8000000B.
- Privilege U via mret (MPP=00), then irq_timer with MIE=0, MTIE=1 -> interrupt taken, privilege 11, MPP 00.
- mret coincident with exception -> exception taken, mret ignored; CSR write coincident -> not acked, retried, applied.
- Read 0x7C0 -> error 1, rdata 0; write mstatus MPP=01 -> reads back 11; i_enable low -> no ack, privilege 11.
